// File: rtl/shift_rotate_seq_unit.sv
// rtl/shift_rotate_seq_unit.sv - iterative shift/rotate/XOR unit with start/busy/done handshake
//
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   start  - request an operation (taken in IDLE or DONE only)
//   term   - operand to shift/rotate, or first XOR operand
//   shamt  - shift amount (low SHIFT_WIDTH bits) or second XOR operand
//   sel    - 0 SLL, 1 SRL, 2 SRA, 3 XOR, 4 ROL, 5 ROR, 6/7 passthrough
//   busy   - high while iterating
//   done   - one-cycle completion pulse
//   result - working/result register, held until the next accepted start
module shift_rotate_seq_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] term,
    input  logic [WIDTH-1:0] shamt,
    input  logic [2:0]       sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int SHIFT_WIDTH = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [WIDTH-1:0]       r_result;
    logic [SHIFT_WIDTH-1:0] r_rem;
    logic [2:0]             r_sel;
    logic                   r_sign;

    logic                   w_accept;
    logic                   w_zero_work;
    logic [SHIFT_WIDTH-1:0] w_k;
    logic [SHIFT_WIDTH-1:0] w_s;
    logic [SHIFT_WIDTH-1:0] w_s_inv;
    logic [WIDTH-1:0]       w_sra_mask;
    logic [WIDTH-1:0]       w_shifted;

    assign w_k         = shamt[SHIFT_WIDTH-1:0];
    assign w_accept    = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_zero_work = (sel == 3'd3) || (sel > 3'd5) || (w_k == '0);

    // Step size is min(STEP, remaining). STEP may equal WIDTH, which does not
    // fit in SHIFT_WIDTH bits, so compare one bit wider. When STEP is chosen,
    // remaining >= STEP and remaining <= WIDTH-1, so STEP fits.
    always_comb begin
        w_s = r_rem;
        if ({1'b0, r_rem} >= (SHIFT_WIDTH+1)'(STEP)) begin
            w_s = SHIFT_WIDTH'(STEP);
        end
    end

    // WIDTH is a power of two, so WIDTH - s wraps to 0 - s in SHIFT_WIDTH bits.
    // s is never zero in RUN, so the rotate complement is always in range.
    assign w_s_inv    = SHIFT_WIDTH'(0) - w_s;
    assign w_sra_mask = ~({WIDTH{1'b1}} >> w_s);

    always_comb begin
        w_shifted = r_result;
        case (r_sel)
            3'd0:    w_shifted = r_result << w_s;
            3'd1:    w_shifted = r_result >> w_s;
            3'd2:    w_shifted = (r_result >> w_s) | (r_sign ? w_sra_mask : '0);
            3'd4:    w_shifted = (r_result << w_s) | (r_result >> w_s_inv);
            3'd5:    w_shifted = (r_result >> w_s) | (r_result << w_s_inv);
            default: w_shifted = r_result;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_zero_work ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_rem == w_s) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_accept) begin
                    w_state_next = w_zero_work ? ST_DONE : ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_rem    <= '0;
            r_sel    <= '0;
            r_sign   <= 1'b0;
        end else if (w_accept) begin
            r_sel    <= sel;
            r_sign   <= term[WIDTH-1];
            r_rem    <= w_zero_work ? '0 : w_k;
            r_result <= (sel == 3'd3) ? (term ^ shamt) : term;
        end else if (r_state == ST_RUN) begin
            r_result <= w_shifted;
            r_rem    <= r_rem - w_s;
        end
    end

    assign busy   = (r_state == ST_RUN);
    assign done   = (r_state == ST_DONE);
    assign result = r_result;

endmodule

// File: tb/tb_shift_rotate_seq_unit.sv
// tb/tb_shift_rotate_seq_unit.sv - randomized self-checking bench for shift_rotate_seq_unit
module tb_shift_rotate_seq_unit;
    localparam int W    = 32;
    localparam int STEP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  term;
    logic [W-1:0]  shamt;
    logic [2:0]    sel;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;

    int total = 0;
    int bad   = 0;

    shift_rotate_seq_unit #(.WIDTH(W), .STEP(STEP)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .term   (term),
        .shamt  (shamt),
        .sel    (sel),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [2:0] s, input logic [W-1:0] t,
                                           input logic [W-1:0] a);
        int k;
        k = int'(a[4:0]);
        case (s)
            3'd0:    return t << k;
            3'd1:    return t >> k;
            3'd2:    return W'($signed(t) >>> k);
            3'd3:    return t ^ a;
            3'd4:    return (k == 0) ? t : ((t << k) | (t >> (W - k)));
            3'd5:    return (k == 0) ? t : ((t >> k) | (t << (W - k)));
            default: return t;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] s, input logic [W-1:0] a);
        int k;
        k = int'(a[4:0]);
        if (s == 3'd3 || s > 3'd5 || k == 0) return 1;
        return (k + STEP - 1) / STEP + 1;
    endfunction

    // Launches one op, then waits for done. n counts negedges after the accept
    // edge, so n == latency when done is first seen.
    task automatic run_op(input string tag, input logic [2:0] s, input logic [W-1:0] t,
                          input logic [W-1:0] a, input logic [W-1:0] exp_res, input int exp_lat);
        int n;
        @(negedge clk);
        start = 1'b1; sel = s; term = t; shamt = a;
        @(negedge clk);
        start = 1'b0; term = $urandom; shamt = $urandom; sel = 3'($urandom);
        n = 1;
        while (!done && n < 100) begin
            check({tag, "_busy"}, W'(busy), W'(1));
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, W'(n), W'(exp_lat));
        check({tag, "_res"}, result, exp_res);
        check({tag, "_busy_at_done"}, W'(busy), W'(0));
    endtask

    initial begin
        int n;
        logic [W-1:0] t, a;
        logic [2:0]   s;

        rst = 1'b1; start = 1'b0; term = '0; shamt = '0; sel = '0;
        repeat (2) @(negedge clk);
        check("reset_result", result, 32'h0);
        check("reset_busy", W'(busy), W'(0));
        check("reset_done", W'(done), W'(0));
        rst = 1'b0;

        run_op("sll5",   3'd0, 32'h000000F1, 32'd5,        32'h00001E20, 3);
        run_op("sra31",  3'd2, 32'h80000000, 32'd31,       32'hFFFFFFFF, 9);
        run_op("srl31",  3'd1, 32'h80000000, 32'd31,       32'h00000001, 9);
        run_op("ror1",   3'd5, 32'h00000001, 32'd1,        32'h80000000, 2);
        run_op("rol4",   3'd4, 32'h80000001, 32'd4,        32'h00000018, 2);
        run_op("xor",    3'd3, 32'hFFFF0000, 32'h12345678, 32'hEDCB5678, 1);
        run_op("sll_k0", 3'd0, 32'hA5A5_1234, 32'h20,      32'hA5A5_1234, 1);
        run_op("rsv7",   3'd7, 32'hDEAD_BEEF, 32'h3,       32'hDEAD_BEEF, 1);

        // Second start mid-RUN must be ignored.
        @(negedge clk);
        start = 1'b1; sel = 3'd0; term = 32'h0000_0003; shamt = 32'd31;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        repeat (2) begin @(negedge clk); n++; end
        start = 1'b1; sel = 3'd3; term = 32'h1234_5678; shamt = 32'hFFFF_FFFF;
        @(negedge clk); n++;
        start = 1'b0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        check("ignore_lat", W'(n), W'(9));
        check("ignore_res", result, 32'h8000_0000);

        // Reset mid-RUN aborts with no later done.
        @(negedge clk);
        start = 1'b1; sel = 3'd4; term = 32'hF0F0_F0F0; shamt = 32'd30;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_result", result, 32'h0);
        check("abort_busy", W'(busy), W'(0));
        check("abort_done", W'(done), W'(0));
        n = 0;
        repeat (12) begin @(negedge clk); if (done) n++; end
        check("abort_no_done", W'(n), W'(0));

        // Back-to-back: start held in DONE accepts an XOR with no gap.
        @(negedge clk);
        start = 1'b1; sel = 3'd1; term = 32'hF000_0000; shamt = 32'd8;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 100) begin @(negedge clk); n++; end
        check("b2b_first_lat", W'(n), W'(3));
        check("b2b_first_res", result, 32'h00F0_0000);
        start = 1'b1; sel = 3'd3; term = 32'h0F0F_0F0F; shamt = 32'hFF00_FF00;
        @(negedge clk);
        start = 1'b0;
        check("b2b_second_done", W'(done), W'(1));
        check("b2b_second_res", result, 32'hF00F_F00F);
        @(negedge clk);
        check("b2b_idle_done", W'(done), W'(0));
        check("b2b_hold_res", result, 32'hF00F_F00F);

        // Randomized ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            s = 3'($urandom_range(0, 7));
            t = $urandom;
            a = (i % 2 == 0) ? W'($urandom_range(0, 31)) : W'($urandom);
            run_op($sformatf("rnd%0d_sel%0d", i, s), s, t, a, model(s, t, a), model_lat(s, a));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
